alarm_ctrl: RTL and testbench

- Downstream of the arming driver in the car anti-theft path.
- Consumes the driver's `armar` level plus the raw `door` and `ignicao` sensors, and runs the armed / entry-delay / siren state machine.
- Drives the siren, the status LED, the state code and the 4-bit countdown shown on the display.
- Internal prescaler generates the time base; all delays are in prescaler ticks.

---
 rtl/alarm_ctrl_if.sv | 22 ++
 rtl/alarm_ctrl.sv | 176 +++++++++++++++++
 tb/tb_alarm_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_if.sv
// Sensor/actuator bundle between the anti-theft controller and its surroundings.
// The master side drives the arm level and the raw sensors and observes the
// siren, LED, state code and countdown. The slave side is the controller.
interface alarm_ctrl_if;
  logic       armar;    // arm level from the arming driver, 1 = armed requested
  logic       door;     // door sensor, 1 = open
  logic       ignicao;  // ignition key, 1 = on
  logic       siren;    // siren drive
  logic       led;      // status LED
  logic [1:0] state;    // 0=DISARMED 1=ARMED 2=ENTRY 3=ALARM
  logic [3:0] count;    // countdown shown on the display

  modport master (
    output armar, door, ignicao,
    input  siren, led, state, count
  );

  modport slave (
    input  armar, door, ignicao,
    output siren, led, state, count
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Car anti-theft controller: armed / entry-delay / siren state machine.
// A free-running prescaler produces one tick every TICK_DIV cycles and is
// restarted on every state change, so every timed state lasts an exact
// multiple of TICK_DIV cycles. Ignition on always forces DISARMED.
// Optional feature macro: STATUS_BLINK_EN -- blinks the LED while ARMED,
// toggling every BLINK_DIV ticks.
module alarm_ctrl #(
  parameter int TICK_DIV  = 4,  // clock cycles per tick (>= 2)
  parameter int T_ENTRY   = 3,  // entry delay in ticks (1..15)
  parameter int T_SIREN   = 5   // siren duration in ticks (1..15)
`ifdef STATUS_BLINK_EN
  , parameter int BLINK_DIV = 2 // ticks per LED half-period (1..15)
`endif
) (
  input  logic        clock,
  input  logic        reset,    // asynchronous, active-low
  alarm_ctrl_if.slave io
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [3:0]     ENTRY_LOAD = 4'(T_ENTRY);
  localparam logic [3:0]     SIREN_LOAD = 4'(T_SIREN);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_ENTRY    = 2'd2,
    ST_ALARM    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          door_q;
  logic          siren_q;
  logic          led_q, led_d;
  logic          door_rise;
  logic          tick;

  // Only a fresh opening seen while armed may start the entry delay; a door
  // already open when arming completes does not count.
  assign door_rise = io.door & ~door_q;
  assign tick      = (presc_q == PRESC_MAX);

  // Next state and countdown; ignition overrides every state-specific rule.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    count_d = count_q;
    if (io.ignicao) begin
      state_d = ST_DISARMED;
      count_d = 4'd0;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (io.armar) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (!io.armar) begin
            state_d = ST_DISARMED;
          end else if (door_rise) begin
            state_d = ST_ENTRY;
            count_d = ENTRY_LOAD;
          end
        end
        ST_ENTRY: begin
          // armar and door are deliberately ignored: only ignition aborts.
          if (tick) begin
            if (count_q > 4'd1) begin
              count_d = count_q - 4'd1;
            end else if (count_q == 4'd1) begin
              state_d = ST_ALARM;
              count_d = SIREN_LOAD;
            end
          end
        end
        ST_ALARM: begin
          if (tick) begin
            if (count_q > 4'd1) begin
              count_d = count_q - 4'd1;
            end else if (count_q == 4'd1) begin
              count_d = 4'd0;
              state_d = io.armar ? ST_ARMED : ST_DISARMED;
            end
          end
        end
        default: begin
          state_d = ST_DISARMED;
          count_d = 4'd0;
        end
      endcase
    end
  end

  // Prescaler restarts on any state change so the first tick of a state
  // arrives a full TICK_DIV cycles after entering it.
  always_comb begin
    if (state_d != state_q) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

`ifdef STATUS_BLINK_EN
  localparam logic [3:0] BLINK_MAX = 4'(BLINK_DIV - 1);

  logic [3:0] blink_cnt_q, blink_cnt_d;
  logic       blink_q, blink_d;

  // Blink phase: restarts dark on entering ARMED, toggles every BLINK_DIV ticks.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (state_d == ST_ARMED && state_q != ST_ARMED) begin
      blink_cnt_d = 4'd0;
      blink_d     = 1'b0;
    end else if (state_q == ST_ARMED && tick) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = 4'd0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 4'd1;
      end
    end
    led_d = (state_d == ST_ARMED) ? blink_d : (state_d != ST_DISARMED);
  end

  // Blink phase registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= 4'd0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end
`else
  // Steady LED: lit whenever the system is not disarmed.
  always_comb begin
    led_d = (state_d != ST_DISARMED);
  end
`endif

  // State, countdown, prescaler, door history and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_DISARMED;
      count_q <= 4'd0;
      presc_q <= '0;
      door_q  <= 1'b0;
      siren_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      door_q  <= io.door;
      siren_q <= (state_d == ST_ALARM);
      led_q   <= led_d;
    end
  end

  assign io.state = state_q;
  assign io.count = count_q;
  assign io.siren = siren_q;
  assign io.led   = led_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed walk through the arming,
// entry, siren, ignition-abort and async-reset scenarios with literal
// expectations, followed by randomized sensor traffic. A cycle-count model
// (time spent in the current mode) predicts every output on every cycle.
module tb_alarm_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int T_ENTRY   = 3;
  localparam int T_SIREN   = 5;
  localparam int BLINK_DIV = 2;

  localparam int M_DISARMED = 0;
  localparam int M_ARMED    = 1;
  localparam int M_ENTRY    = 2;
  localparam int M_ALARM    = 3;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alarm_ctrl_if io ();

  alarm_ctrl #(
    .TICK_DIV (TICK_DIV),
    .T_ENTRY  (T_ENTRY),
    .T_SIREN  (T_SIREN)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode plus the number of cycles already spent in it; countdown and
  // expiry follow from elapsed time divided by the tick length.
  int m_mode    = M_DISARMED;
  int m_elapsed = 0;
  bit m_door_q  = 1'b0;

  always @(posedge clock or negedge reset) begin
    int nxt;
    if (!reset) begin
      m_mode    = M_DISARMED;
      m_elapsed = 0;
      m_door_q  = 1'b0;
    end else begin
      nxt = m_mode;
      if (io.ignicao) begin
        nxt = M_DISARMED;
      end else begin
        case (m_mode)
          M_DISARMED: if (io.armar) nxt = M_ARMED;
          M_ARMED: begin
            if (!io.armar) nxt = M_DISARMED;
            else if (io.door && !m_door_q) nxt = M_ENTRY;
          end
          M_ENTRY: if (m_elapsed + 1 == T_ENTRY * TICK_DIV) nxt = M_ALARM;
          default: if (m_elapsed + 1 == T_SIREN * TICK_DIV) nxt = io.armar ? M_ARMED : M_DISARMED;
        endcase
      end
      if (nxt != m_mode) m_elapsed = 0;
      else m_elapsed++;
      m_mode   = nxt;
      m_door_q = io.door;
    end
  end

  function automatic int exp_count();
    if (m_mode == M_ENTRY) return T_ENTRY - m_elapsed / TICK_DIV;
    if (m_mode == M_ALARM) return T_SIREN - m_elapsed / TICK_DIV;
    return 0;
  endfunction

  function automatic int exp_led();
`ifdef STATUS_BLINK_EN
    if (m_mode == M_ARMED) return (m_elapsed / (TICK_DIV * BLINK_DIV)) % 2;
`endif
    return (m_mode != M_DISARMED) ? 1 : 0;
  endfunction

  // Compare every output against the model midway between rising edges.
  always @(negedge clock) begin
    check("mdl_state", 32'(io.state), 32'(m_mode));
    check("mdl_count", 32'(io.count), 32'(exp_count()));
    check("mdl_siren", 32'(io.siren), (m_mode == M_ALARM) ? 32'd1 : 32'd0);
    check("mdl_led",   32'(io.led),   32'(exp_led()));
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset      = 1'b0;
    io.armar   = 1'b0;
    io.door    = 1'b0;
    io.ignicao = 1'b0;

    // Reset values.
    repeat (2) @(posedge clock);
    #1;
    check("rst_state", 32'(io.state), 32'd0);
    check("rst_count", 32'(io.count), 32'd0);
    check("rst_siren", 32'(io.siren), 32'd0);
    check("rst_led",   32'(io.led),   32'd0);
    reset = 1'b1;

    // Arm.
    io.armar = 1'b1;
    step(1);
    check("arm_state", 32'(io.state), 32'd1);
    check("arm_count", 32'(io.count), 32'd0);
    check("arm_siren", 32'(io.siren), 32'd0);
`ifdef STATUS_BLINK_EN
    check("arm_led",   32'(io.led),   32'd0);
`else
    check("arm_led",   32'(io.led),   32'd1);
`endif

    // Door pulse: entry countdown, then siren, then back to ARMED.
    io.door = 1'b1;
    step(1);
    io.door = 1'b0;
    check("entry_state", 32'(io.state), 32'd2);
    check("entry_load",  32'(io.count), 32'd3);
    step(4);
    check("entry_cnt2",  32'(io.count), 32'd2);
    step(4);
    check("entry_cnt1",  32'(io.count), 32'd1);
    step(4);
    check("alarm_state", 32'(io.state), 32'd3);
    check("alarm_load",  32'(io.count), 32'd5);
    check("alarm_siren", 32'(io.siren), 32'd1);
    for (int i = 0; i < 19; i++) begin
      step(1);
      check("alarm_hold", 32'(io.siren), 32'd1);
    end
    step(1);
    check("post_state", 32'(io.state), 32'd1);
    check("post_siren", 32'(io.siren), 32'd0);
    check("post_count", 32'(io.count), 32'd0);

    // Ignition aborts the entry delay.
    io.door = 1'b1;
    step(1);
    io.door = 1'b0;
    step(4);
    check("ign_pre_cnt", 32'(io.count), 32'd2);
    io.ignicao = 1'b1;
    step(1);
    check("ign_state", 32'(io.state), 32'd0);
    check("ign_count", 32'(io.count), 32'd0);
    check("ign_siren", 32'(io.siren), 32'd0);
    io.ignicao = 1'b0;
    step(1);
    check("rearm_state", 32'(io.state), 32'd1);

    // Door held open through siren expiry: no re-trigger until a new rise.
    io.door = 1'b1;
    step(1);
    check("held_entry", 32'(io.state), 32'd2);
    step(32);
    check("held_armed", 32'(io.state), 32'd1);
    step(8);
    check("held_stay", 32'(io.state), 32'd1);
    io.door = 1'b0;
    step(1);
    io.door = 1'b1;
    step(1);
    check("retrig_state", 32'(io.state), 32'd2);

    // Asynchronous reset in the middle of the siren.
    step(12);
    check("pre_rst_alarm", 32'(io.state), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("async_state", 32'(io.state), 32'd0);
    check("async_siren", 32'(io.siren), 32'd0);
    check("async_count", 32'(io.count), 32'd0);
    check("async_led",   32'(io.led),   32'd0);
    io.door = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    step(1);

    // Randomized sensor traffic against the model.
    io.armar = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3)  io.armar = ~io.armar;
      if ($urandom_range(0, 99) < 15) io.door  = ~io.door;
      io.ignicao = ($urandom_range(0, 99) < 2);
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
